spi_mem_reader: RTL and testbench

Initiator-side sequencer for the memory-test SPI link: on a start request it frames a transaction with chip-select, sends a 16-bit start address MSB-first, clocks out dummy bytes, then reads a programmable number of data bytes back from the memory responder. It sits between the test controller and a byte-level SPI master. It presents each returned byte with its address, and optionally checks it against the test pattern.

---
 rtl/mem_test_pkg.sv | 24 ++
 rtl/mem_pattern_chk.sv | 42 ++++
 rtl/spi_mem_reader.sv | 185 ++++++++++++++++++
 tb/tb_spi_mem_reader.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_test_pkg.sv
// Shared types and constants for the memory-test SPI link: sequencer states,
// fill byte, address width and the test pattern shared with the responder.
package mem_test_pkg;

  localparam int ADDR_W = 16;
  localparam logic [7:0] FILL_BYTE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DUMMY,
    ST_DATA,
    ST_CS_HOLD,
    ST_GAP
  } state_e;

  // Memory contents written by the responder-side generator.
  function automatic logic [7:0] exp_byte(input logic [ADDR_W-1:0] addr);
    return addr[7:0] ^ addr[15:8];
  endfunction

endpackage

// File: rtl/mem_pattern_chk.sv
// Compares returned data bytes against the test pattern and keeps a
// saturating mismatch count; cleared whenever a new transaction is accepted.
module mem_pattern_chk
  import mem_test_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_valid,
  input  logic [7:0]        i_byte,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_err,
  output logic [15:0]       o_err_cnt
);

  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    err_d = i_valid && (i_byte != exp_byte(i_addr));
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (err_d && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_err     = err_q;
  assign o_err_cnt = cnt_q;

endmodule

// File: rtl/spi_mem_reader.sv
// SPI memory-read sequencer: CS framing, 16-bit address, dummy bytes, N data
// bytes; one byte in flight at a time. Pattern checking under MEM_TEST_CHECK_EN.
//
// state       | meaning
// IDLE        | waiting for i_start
// CS_SETUP    | CS asserted, one setup cycle
// ADDR_HI/LO  | address bytes, MSB first
// DUMMY       | turnaround bytes, rx data discarded
// DATA        | read bytes, presented with their address
// CS_HOLD     | one cycle after last byte, CS still low
// GAP         | CS high for CS_GAP cycles, then done
module spi_mem_reader
  import mem_test_pkg::*;
#(
  parameter int DUMMY_BYTES = 1,
  parameter int LEN_W       = 8,
  parameter int CS_GAP      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_busy,
  output logic              o_cs_n,
  output logic [7:0]        o_tx_byte,
  output logic              o_tx_dv,
  input  logic              i_tx_ready,
  input  logic [7:0]        i_rx_byte,
  input  logic              i_rx_dv,
  output logic [7:0]        o_rd_byte,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_valid,
  output logic              o_done,
  output logic              o_err,
  output logic [15:0]       o_err_cnt
);

  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_GAP - 1);
  localparam logic [1:0] DUMMY_LOAD = (DUMMY_BYTES > 0) ? 2'(DUMMY_BYTES - 1) : 2'd0;
  localparam bit HAS_DUMMY = (DUMMY_BYTES > 0);

  state_e            state_q, state_d;
  logic              wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [1:0]        dum_q, dum_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [7:0]        rd_byte_q, rd_byte_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;

  logic   accept, byte_state, tx_fire, rx_fire, data_fire;
  state_e after_hdr;

  assign accept     = (state_q == ST_IDLE) && i_start;
  assign byte_state = (state_q == ST_ADDR_HI) || (state_q == ST_ADDR_LO) ||
                      (state_q == ST_DUMMY)   || (state_q == ST_DATA);
  // ISSUE sub-phase is !wait_q, WAIT sub-phase is wait_q.
  assign tx_fire    = byte_state && !wait_q && i_tx_ready;
  assign rx_fire    = byte_state && wait_q && i_rx_dv;
  assign data_fire  = rx_fire && (state_q == ST_DATA);
  assign after_hdr  = (rem_q != '0) ? ST_DATA : ST_CS_HOLD;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = ST_CS_SETUP;
      ST_CS_SETUP: state_d = ST_ADDR_HI;
      ST_ADDR_HI:  if (rx_fire) state_d = ST_ADDR_LO;
      ST_ADDR_LO:  if (rx_fire) state_d = HAS_DUMMY ? ST_DUMMY : after_hdr;
      ST_DUMMY:    if (rx_fire && (dum_q == 2'd0)) state_d = after_hdr;
      ST_DATA:     if (rx_fire && (rem_q == LEN_W'(1))) state_d = ST_CS_HOLD;
      ST_CS_HOLD:  state_d = ST_GAP;
      ST_GAP:      if (gap_q == '0) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy    = (state_q != ST_IDLE);
    o_cs_n    = (state_q == ST_IDLE) || (state_q == ST_GAP);
    o_tx_dv   = tx_fire;
    o_tx_byte = FILL_BYTE;
    case (state_q)
      ST_ADDR_HI: o_tx_byte = addr_q[15:8];
      ST_ADDR_LO: o_tx_byte = addr_q[7:0];
      default:    o_tx_byte = FILL_BYTE;
    endcase
    o_rd_byte  = rd_byte_q;
    o_rd_addr  = rd_addr_q;
    o_rd_valid = rd_valid_q;
    o_done     = done_q;
  end

  always_comb begin
    wait_d = wait_q;
    if (tx_fire) begin
      wait_d = 1'b1;
    end else if (rx_fire) begin
      wait_d = 1'b0;
    end

    addr_d = addr_q;
    rem_d  = rem_q;
    if (accept) begin
      addr_d = i_addr;
      rem_d  = i_len;
    end else if (data_fire) begin
      addr_d = addr_q + 16'd1;
      rem_d  = rem_q - LEN_W'(1);
    end

    dum_d = dum_q;
    if (state_q == ST_ADDR_LO) begin
      dum_d = DUMMY_LOAD;
    end else if ((state_q == ST_DUMMY) && rx_fire) begin
      dum_d = dum_q - 2'd1;
    end

    gap_d = gap_q;
    if (state_q == ST_CS_HOLD) begin
      gap_d = GAP_LOAD;
    end else if ((state_q == ST_GAP) && (gap_q != '0)) begin
      gap_d = gap_q - GAP_W'(1);
    end

    rd_byte_d  = data_fire ? i_rx_byte : rd_byte_q;
    rd_addr_d  = data_fire ? addr_q : rd_addr_q;
    rd_valid_d = data_fire;
    done_d     = (state_q == ST_GAP) && (gap_q == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_q     <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      dum_q      <= '0;
      gap_q      <= '0;
      rd_byte_q  <= '0;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wait_q     <= wait_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      dum_q      <= dum_d;
      gap_q      <= gap_d;
      rd_byte_q  <= rd_byte_d;
      rd_addr_q  <= rd_addr_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

`ifdef MEM_TEST_CHECK_EN
  // Registered compare so o_err lines up with o_rd_valid.
  mem_pattern_chk u_chk (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (accept),
    .i_valid   (data_fire),
    .i_byte    (i_rx_byte),
    .i_addr    (addr_q),
    .o_err     (o_err),
    .o_err_cnt (o_err_cnt)
  );
`else
  assign o_err     = 1'b0;
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_spi_mem_reader.sv
// Self-checking bench for spi_mem_reader: byte-level SPI master model plus a
// transaction-level reference for TX bytes, read addresses/data and errors.
module tb_spi_mem_reader;

  localparam int DUMMY  = 1;
  localparam int LEN_W  = 8;
  localparam int CS_GAP = 4;
`ifdef MEM_TEST_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, tx_ready, rx_dv;
  logic [15:0] addr;
  logic [7:0]  len, rx_byte;
  logic        busy, cs_n, tx_dv, rd_valid, done, err;
  logic [7:0]  tx_byte, rd_byte;
  logic [15:0] rd_addr, err_cnt;

  spi_mem_reader #(.DUMMY_BYTES(DUMMY), .LEN_W(LEN_W), .CS_GAP(CS_GAP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_addr(addr), .i_len(len),
    .o_busy(busy), .o_cs_n(cs_n), .o_tx_byte(tx_byte), .o_tx_dv(tx_dv),
    .i_tx_ready(tx_ready), .i_rx_byte(rx_byte), .i_rx_dv(rx_dv),
    .o_rd_byte(rd_byte), .o_rd_addr(rd_addr), .o_rd_valid(rd_valid),
    .o_done(done), .o_err(err), .o_err_cnt(err_cnt)
  );

  int total = 0;
  int bad   = 0;

  // master model / stimulus state
  int          m_low, m_lat, m_delay, m_latency;
  bit          in_flight, start_req;
  logic [7:0]  m_resp;
  logic [15:0] drv_addr;
  logic [7:0]  drv_len;
  logic [7:0]  resp_q[$];

  // observation logs
  logic [7:0]  tx_log[$];
  logic [7:0]  rdb_log[$];
  logic [15:0] rda_log[$];
  int          err_idx[$];
  int cyc, start_cyc, first_dv_cyc, first_busy_cyc, first_cs_cyc;
  int done_cnt, accepts, viol, gap_run, gap_at_done;
  bit prev_dv, prev_busy;

  function automatic logic [7:0] ref_tx(input logic [15:0] a, input int i);
    if (i == 0) return a[15:8];
    if (i == 1) return a[7:0];
    return 8'h00;
  endfunction

  function automatic logic [15:0] ref_addr(input logic [15:0] a, input int i);
    int s;
    s = (int'(a) + i) % 65536;
    return s[15:0];
  endfunction

  function automatic logic [7:0] pattern(input logic [15:0] x);
    return x[7:0] ^ x[15:8];
  endfunction

  function automatic bit ref_err(input logic [15:0] a, input int i, input logic [7:0] b);
    if (!CHK_EN) return 1'b0;
    return b != pattern(ref_addr(a, i));
  endfunction

  task automatic clear_logs();
    tx_log.delete(); rdb_log.delete(); rda_log.delete(); err_idx.delete();
    first_dv_cyc = -1; first_busy_cyc = -1; first_cs_cyc = -1;
    done_cnt = 0; accepts = 0; viol = 0; gap_run = 0; gap_at_done = -1;
  endtask

  task automatic reset_master();
    in_flight = 0; m_low = 0; m_lat = 0; prev_dv = 0;
  endtask

  // One clock: drive inputs at negedge, sample 1 time unit later.
  task automatic cycle();
    int idx;
    @(negedge clk);
    start = start_req;
    addr  = drv_addr;
    len   = drv_len;
    rx_dv = 1'b0;
    if (in_flight) begin
      tx_ready = 1'b0;
      if (m_lat == 0) begin
        rx_dv = 1'b1; rx_byte = m_resp; in_flight = 0; m_low = m_delay;
      end else begin
        m_lat--;
      end
    end else if (m_low > 0) begin
      tx_ready = 1'b0; m_low--;
    end else begin
      tx_ready = 1'b1;
    end
    if (!rx_dv) rx_byte = 8'($urandom);
    #1;
    cyc++;
    if (tx_dv) begin
      if (!tx_ready || prev_dv || cs_n) viol++;
      if (first_dv_cyc < 0) first_dv_cyc = cyc;
      idx = tx_log.size();
      tx_log.push_back(tx_byte);
      in_flight = 1; m_lat = m_latency;
      if (idx >= 2 + DUMMY && idx - 2 - DUMMY < resp_q.size()) m_resp = resp_q[idx-2-DUMMY];
      else m_resp = 8'($urandom);
    end
    prev_dv = tx_dv;
    if (in_flight && cs_n) viol++;
    if (!cs_n && first_cs_cyc < 0) first_cs_cyc = cyc;
    if (busy && !prev_busy) begin
      accepts++;
      if (first_busy_cyc < 0) first_busy_cyc = cyc;
    end
    prev_busy = busy;
    if (rd_valid) begin rdb_log.push_back(rd_byte); rda_log.push_back(rd_addr); end
    if (err) begin
      err_idx.push_back(rdb_log.size() - 1);
      if (!rd_valid) viol++;
    end
    if (busy && cs_n) gap_run++;
    else if (!cs_n) gap_run = 0;
    if (done) begin
      done_cnt++; gap_at_done = gap_run; gap_run = 0;
      if (busy) viol++;
    end
  endtask

  task automatic start_txn(input logic [15:0] a, input logic [7:0] l,
                           input int delay, input int lat, input bit hold);
    drv_addr = a; drv_len = l; m_delay = delay; m_latency = lat; m_low = delay;
    start_req = 1'b1;
    cycle();
    start_cyc = cyc;
    if (!hold) start_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin cycle(); n++; end
    ok = (done_cnt != 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_req = 0; drv_addr = 16'hA5A5; drv_len = 8'd3;
    reset_master(); clear_logs();
    repeat (3) cycle();
    total++; if (cs_n !== 1'b1)      begin bad++; $display("FAIL reset_cs_n got=%b want=1", cs_n); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (tx_byte !== 8'h00)  begin bad++; $display("FAIL reset_tx_byte got=%h want=00", tx_byte); end
    total++; if (tx_dv !== 1'b0)     begin bad++; $display("FAIL reset_tx_dv got=%b want=0", tx_dv); end
    total++; if (rd_byte !== 8'h00)  begin bad++; $display("FAIL reset_rd_byte got=%h want=00", rd_byte); end
    total++; if (rd_addr !== 16'h0)  begin bad++; $display("FAIL reset_rd_addr got=%h want=0000", rd_addr); end
    total++; if (rd_valid !== 1'b0)  begin bad++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (err !== 1'b0)       begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (err_cnt !== 16'h0)  begin bad++; $display("FAIL reset_err_cnt got=%h want=0000", err_cnt); end
    rst_n = 1'b1;
    repeat (2) cycle();
  endtask

  task automatic test_single_read();
    bit ok;
    clear_logs(); resp_q = '{8'h26};
    start_txn(16'h1234, 8'd1, 0, 0, 0);
    wait_done(200, ok);
    repeat (3) cycle();
    total++; if (!ok) begin bad++; $display("FAIL single_timeout no done"); end
    total++; if (first_busy_cyc - start_cyc !== 1) begin bad++; $display("FAIL single_busy_lat got=%0d want=1", first_busy_cyc - start_cyc); end
    total++; if (first_cs_cyc - start_cyc !== 1) begin bad++; $display("FAIL single_cs_lat got=%0d want=1", first_cs_cyc - start_cyc); end
    total++; if (first_dv_cyc - start_cyc !== 2) begin bad++; $display("FAIL single_dv_lat got=%0d want=2", first_dv_cyc - start_cyc); end
    total++; if (tx_log.size() !== 2 + DUMMY + 1) begin bad++; $display("FAIL single_tx_count got=%0d want=%0d", tx_log.size(), 3 + DUMMY); end
    for (int i = 0; i < tx_log.size(); i++) begin
      total++; if (tx_log[i] !== ref_tx(16'h1234, i)) begin bad++; $display("FAIL single_tx[%0d] got=%h want=%h", i, tx_log[i], ref_tx(16'h1234, i)); end
    end
    total++; if (rdb_log.size() !== 1) begin bad++; $display("FAIL single_rd_count got=%0d want=1", rdb_log.size()); end
    else begin
      total++; if (rdb_log[0] !== 8'h26)   begin bad++; $display("FAIL single_rd_byte got=%h want=26", rdb_log[0]); end
      total++; if (rda_log[0] !== 16'h1234) begin bad++; $display("FAIL single_rd_addr got=%h want=1234", rda_log[0]); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL single_done_count got=%0d want=1", done_cnt); end
    total++; if (err_idx.size() !== 0) begin bad++; $display("FAIL single_err got=%0d want=0", err_idx.size()); end
    total++; if (viol !== 0) begin bad++; $display("FAIL single_protocol violations=%0d want=0", viol); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [15:0] exp_a[4];
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    clear_logs(); resp_q.delete();
    for (int i = 0; i < 4; i++) resp_q.push_back(8'($urandom));
    start_txn(16'hFFFE, 8'd4, 0, 1, 0);
    wait_done(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_timeout no done"); end
    total++; if (rda_log.size() !== 4) begin bad++; $display("FAIL wrap_rd_count got=%0d want=4", rda_log.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (rda_log[i] !== exp_a[i]) begin bad++; $display("FAIL wrap_addr[%0d] got=%h want=%h", i, rda_log[i], exp_a[i]); end
        total++; if (rdb_log[i] !== resp_q[i]) begin bad++; $display("FAIL wrap_byte[%0d] got=%h want=%h", i, rdb_log[i], resp_q[i]); end
      end
    end
  endtask

  task automatic test_slow_master();
    bit ok;
    logic [15:0] a;
    a = 16'($urandom);
    clear_logs(); resp_q.delete();
    for (int i = 0; i < 3; i++) resp_q.push_back(pattern(ref_addr(a, i)));
    start_txn(a, 8'd3, 10, 1, 0);
    wait_done(1000, ok);
    total++; if (!ok) begin bad++; $display("FAIL slow_timeout no done"); end
    total++; if (viol !== 0) begin bad++; $display("FAIL slow_protocol violations=%0d want=0", viol); end
    total++; if (tx_log.size() !== 2 + DUMMY + 3) begin bad++; $display("FAIL slow_tx_count got=%0d want=%0d", tx_log.size(), 5 + DUMMY); end
    total++; if (rdb_log.size() !== 3) begin bad++; $display("FAIL slow_rd_count got=%0d want=3", rdb_log.size()); end
  endtask

  task automatic test_addr_only();
    bit ok;
    clear_logs(); resp_q.delete();
    start_txn(16'h5A3C, 8'd0, 0, 0, 1);
    wait_done(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL addronly_timeout no done"); end
    total++; if (tx_log.size() !== 2 + DUMMY) begin bad++; $display("FAIL addronly_tx_count got=%0d want=%0d", tx_log.size(), 2 + DUMMY); end
    total++; if (rdb_log.size() !== 0) begin bad++; $display("FAIL addronly_rd_count got=%0d want=0", rdb_log.size()); end
    total++; if (gap_at_done !== CS_GAP) begin bad++; $display("FAIL addronly_gap got=%0d want=%0d", gap_at_done, CS_GAP); end
    total++; if (accepts !== 1) begin bad++; $display("FAIL addronly_reaccept accepts=%0d want=1", accepts); end
    cycle();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL back_to_back_busy got=%b want=1", busy); end
    start_req = 1'b0; done_cnt = 0;
    wait_done(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL back_to_back_timeout no done"); end
    total++; if (tx_log.size() !== 2 * (2 + DUMMY)) begin bad++; $display("FAIL back_to_back_tx_count got=%0d want=%0d", tx_log.size(), 2 * (2 + DUMMY)); end
    total++; if (accepts !== 2) begin bad++; $display("FAIL back_to_back_accepts got=%0d want=2", accepts); end
    total++; if (viol !== 0) begin bad++; $display("FAIL addronly_protocol violations=%0d want=0", viol); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    logic [15:0] a;
    clear_logs(); resp_q.delete();
    for (int i = 0; i < 4; i++) resp_q.push_back(8'($urandom));
    start_txn(16'h2040, 8'd4, 0, 2, 0);
    while (tx_log.size() < 2 + DUMMY + 2 && n < 300) begin cycle(); n++; end
    total++; if (tx_log.size() !== 2 + DUMMY + 2) begin bad++; $display("FAIL rstmid_reach tx=%0d want=%0d", tx_log.size(), 4 + DUMMY); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL rstmid_cs_n got=%b want=1", cs_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (tx_dv !== 1'b0) begin bad++; $display("FAIL rstmid_tx_dv got=%b want=0", tx_dv); end
    reset_master();
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (12) cycle();
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL rstmid_done got=%0d want=0", done_cnt); end
    total++; if (rdb_log.size() !== 1) begin bad++; $display("FAIL rstmid_rd_count got=%0d want=1", rdb_log.size()); end
    a = 16'($urandom);
    clear_logs(); resp_q = '{8'($urandom), 8'($urandom)};
    start_txn(a, 8'd2, 1, 0, 0);
    wait_done(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_fresh_timeout no done"); end
    total++; if (rda_log.size() !== 2) begin bad++; $display("FAIL rstmid_fresh_count got=%0d want=2", rda_log.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        total++; if (rda_log[i] !== ref_addr(a, i) || rdb_log[i] !== resp_q[i]) begin bad++; $display("FAIL rstmid_fresh[%0d] got=%h/%h want=%h/%h", i, rda_log[i], rdb_log[i], ref_addr(a, i), resp_q[i]); end
      end
    end
  endtask

  task automatic test_checker();
    bit ok;
    int exp_n;
    clear_logs(); resp_q = '{8'h01, 8'hFF, 8'h03};
    start_txn(16'h0100, 8'd3, 0, 0, 0);
    wait_done(300, ok);
    exp_n = CHK_EN ? 1 : 0;
    total++; if (!ok) begin bad++; $display("FAIL chk_timeout no done"); end
    total++; if (err_idx.size() !== exp_n) begin bad++; $display("FAIL chk_err_count got=%0d want=%0d", err_idx.size(), exp_n); end
    else if (exp_n == 1) begin
      total++; if (err_idx[0] !== 1) begin bad++; $display("FAIL chk_err_pos got=%0d want=1", err_idx[0]); end
    end
    total++; if (err_cnt !== 16'(exp_n)) begin bad++; $display("FAIL chk_err_cnt got=%0d want=%0d", err_cnt, exp_n); end
    total++; if (viol !== 0) begin bad++; $display("FAIL chk_protocol violations=%0d want=0", viol); end
  endtask

  task automatic test_random();
    bit ok;
    logic [15:0] a;
    int l, exp_errs;
    int exp_idx[$];
    for (int t = 0; t < 10; t++) begin
      a = 16'($urandom);
      if (t == 0) a = 16'hFFFD;
      l = $urandom_range(0, 6);
      clear_logs(); resp_q.delete(); exp_idx.delete();
      for (int i = 0; i < l; i++)
        resp_q.push_back($urandom_range(0, 1) ? pattern(ref_addr(a, i)) : 8'($urandom));
      for (int i = 0; i < l; i++) if (ref_err(a, i, resp_q[i])) exp_idx.push_back(i);
      exp_errs = exp_idx.size();
      start_txn(a, 8'(l), $urandom_range(0, 3), $urandom_range(0, 3), 0);
      wait_done(500, ok);
      total++; if (!ok) begin bad++; $display("FAIL rand%0d_timeout no done", t); end
      total++; if (tx_log.size() !== 2 + DUMMY + l) begin bad++; $display("FAIL rand%0d_tx_count got=%0d want=%0d", t, tx_log.size(), 2 + DUMMY + l); end
      else for (int i = 0; i < tx_log.size(); i++) begin
        total++; if (tx_log[i] !== ref_tx(a, i)) begin bad++; $display("FAIL rand%0d_tx[%0d] got=%h want=%h", t, i, tx_log[i], ref_tx(a, i)); end
      end
      total++; if (rda_log.size() !== l) begin bad++; $display("FAIL rand%0d_rd_count got=%0d want=%0d", t, rda_log.size(), l); end
      else for (int i = 0; i < l; i++) begin
        total++; if (rda_log[i] !== ref_addr(a, i) || rdb_log[i] !== resp_q[i]) begin bad++; $display("FAIL rand%0d_rd[%0d] got=%h/%h want=%h/%h", t, i, rda_log[i], rdb_log[i], ref_addr(a, i), resp_q[i]); end
      end
      total++; if (err_idx != exp_idx) begin bad++; $display("FAIL rand%0d_err_list got=%0d want=%0d entries", t, err_idx.size(), exp_errs); end
      total++; if (err_cnt !== 16'(exp_errs)) begin bad++; $display("FAIL rand%0d_err_cnt got=%0d want=%0d", t, err_cnt, exp_errs); end
      total++; if (gap_at_done !== CS_GAP) begin bad++; $display("FAIL rand%0d_gap got=%0d want=%0d", t, gap_at_done, CS_GAP); end
      total++; if (viol !== 0) begin bad++; $display("FAIL rand%0d_protocol violations=%0d want=0", t, viol); end
      repeat ($urandom_range(0, 3)) cycle();
    end
  endtask

  initial begin
    cyc = 0; prev_busy = 0;
    start = 0; tx_ready = 1; rx_dv = 0; rx_byte = 0; addr = 0; len = 0;
    test_reset();
    test_single_read();
    test_wrap();
    test_slow_master();
    test_addr_only();
    test_reset_mid();
    test_checker();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
